// File: rtl/qspi_flash_responder_if.sv
// QSPI pad and backing-memory signals between the responder and its environment.
interface qspi_flash_responder_if #(
   parameter int unsigned MEM_AW = 32
);
   logic              sclk_in;
   logic              cs_n_in;
   logic [3:0]        io_in;
   logic [3:0]        io_out;
   logic [3:0]        io_oe;
   logic              mem_rd_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_rdata;

   // Initiator side: drives the QSPI pads and answers memory reads.
   modport master (
      output sclk_in, cs_n_in, io_in, mem_rdata,
      input  io_out, io_oe, mem_rd_en, mem_addr
   );

   // Responder side.
   modport slave (
      input  sclk_in, cs_n_in, io_in, mem_rdata,
      output io_out, io_oe, mem_rd_en, mem_addr
   );
endinterface

// File: rtl/qspi_flash_responder.sv
// QSPI flash target: oversamples the pads on h_clk, decodes read commands and
// streams words from a backing memory out on 1 or 4 IO lines.
module qspi_flash_responder #(
   parameter int unsigned DUMMY_CYCLES = 6,
   parameter int unsigned MEM_AW       = 32
) (
   input  logic                   h_clk,
   input  logic                   h_rst,
   qspi_flash_responder_if.slave  bus,
   output logic                   addr_4b_mode,
   output logic                   busy,
   output logic                   cmd_err
);

   localparam int unsigned CW = 8;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        sclk_sync_q, cs_sync_q;
   logic [3:0]        io_sync0_q, io_sync1_q;
   logic              sclk_prev_q;
   logic              sclk_s, cs_s, rise, fall;
   logic [3:0]        io_s;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [31:0]       shift_q, shift_d;
   logic              quad_q, quad_d, four_q, four_d;
   logic [31:0]       sr_q, sr_d, nxt_q, nxt_d;
   logic              word_done_q, word_done_d;
   logic [MEM_AW-1:0] word_addr_q, word_addr_d;
   logic              dest_sr_q, dest_sr_d;
   logic              rd_d1_q, rd_d1_d;
   logic [3:0]        io_out_q, io_out_d, io_oe_q, io_oe_d;
   logic              rd_en_q, rd_en_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              addr_4b_q, addr_4b_d;
   logic              busy_q, busy_d, cmd_err_q, cmd_err_d;

   logic [7:0]        opc;
   logic [31:0]       addr_next, src;
   logic [MEM_AW-1:0] addr_word;
   logic [CW-1:0]     addr_last;
   logic              word_last;

   assign sclk_s = sclk_sync_q[1];
   assign cs_s   = cs_sync_q[1];
   assign io_s   = io_sync1_q;
   assign rise   = sclk_s & ~sclk_prev_q;
   assign fall   = ~sclk_s & sclk_prev_q;

   // Pad synchronisers, all with the same two-flop latency.
   always_ff @(posedge h_clk) begin
      if (h_rst) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         io_sync0_q  <= 4'h0;
         io_sync1_q  <= 4'h0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], bus.sclk_in};
         cs_sync_q   <= {cs_sync_q[0], bus.cs_n_in};
         io_sync0_q  <= bus.io_in;
         io_sync1_q  <= io_sync0_q;
         sclk_prev_q <= sclk_s;
      end
   end

   // State and datapath registers.
   always_ff @(posedge h_clk) begin
      if (h_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         quad_q      <= 1'b0;
         four_q      <= 1'b0;
         sr_q        <= '0;
         nxt_q       <= '0;
         word_done_q <= 1'b0;
         word_addr_q <= '0;
         dest_sr_q   <= 1'b0;
         rd_d1_q     <= 1'b0;
         io_out_q    <= 4'h0;
         io_oe_q     <= 4'h0;
         rd_en_q     <= 1'b0;
         mem_addr_q  <= '0;
         addr_4b_q   <= 1'b0;
         busy_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         quad_q      <= quad_d;
         four_q      <= four_d;
         sr_q        <= sr_d;
         nxt_q       <= nxt_d;
         word_done_q <= word_done_d;
         word_addr_q <= word_addr_d;
         dest_sr_q   <= dest_sr_d;
         rd_d1_q     <= rd_d1_d;
         io_out_q    <= io_out_d;
         io_oe_q     <= io_oe_d;
         rd_en_q     <= rd_en_d;
         mem_addr_q  <= mem_addr_d;
         addr_4b_q   <= addr_4b_d;
         busy_q      <= busy_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   // Next-state, fetch and pad-drive logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      quad_d      = quad_q;
      four_d      = four_q;
      sr_d        = sr_q;
      nxt_d       = nxt_q;
      word_done_d = word_done_q;
      word_addr_d = word_addr_q;
      dest_sr_d   = dest_sr_q;
      rd_d1_d     = rd_en_q;
      io_out_d    = io_out_q;
      io_oe_d     = io_oe_q;
      rd_en_d     = 1'b0;
      mem_addr_d  = mem_addr_q;
      addr_4b_d   = addr_4b_q;
      cmd_err_d   = 1'b0;
      opc         = {shift_q[6:0], io_s[0]};
      addr_next   = quad_q ? {shift_q[27:0], io_s} : {shift_q[30:0], io_s[0]};
      addr_word   = MEM_AW'(addr_next) & ~MEM_AW'(3);
      addr_last   = quad_q ? (four_q ? CW'(7) : CW'(5)) : (four_q ? CW'(31) : CW'(23));
      src         = word_done_q ? nxt_q : sr_q;
      word_last   = quad_q ? (cnt_q == CW'(7)) : (cnt_q == CW'(31));

      // Memory data arrives one cycle after the strobe.
      if (rd_d1_q) begin
         if (dest_sr_q) sr_d = bus.mem_rdata;
         else           nxt_d = bus.mem_rdata;
      end

      case (state_q)
         ST_IDLE: begin
            if (!cs_s) begin
               state_d = ST_CMD;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         ST_CMD: begin
            if (rise) begin
               shift_d = {shift_q[30:0], io_s[0]};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(7)) begin
                  cnt_d   = '0;
                  shift_d = '0;
                  state_d = ST_ADDR;
                  case (opc)
                     8'h03: begin quad_d = 1'b0; four_d = addr_4b_q; end
                     8'h13: begin quad_d = 1'b0; four_d = 1'b1;      end
                     8'hEB: begin quad_d = 1'b1; four_d = addr_4b_q; end
                     8'hEC: begin quad_d = 1'b1; four_d = 1'b1;      end
                     8'hB7: begin addr_4b_d = 1'b1; state_d = ST_IGNORE; end
                     default: begin cmd_err_d = 1'b1; state_d = ST_IGNORE; end
                  endcase
               end
            end
         end
         ST_ADDR: begin
            if (rise) begin
               shift_d = addr_next;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == addr_last) begin
                  cnt_d       = '0;
                  rd_en_d     = 1'b1;
                  dest_sr_d   = 1'b1;
                  mem_addr_d  = addr_word;
                  word_addr_d = addr_word;
                  word_done_d = 1'b0;
                  state_d     = (quad_q && DUMMY_CYCLES != 0) ? ST_DUMMY : ST_DATA;
               end
            end
         end
         ST_DUMMY: begin
            if (rise) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(DUMMY_CYCLES - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (fall) begin
               if (quad_q) begin
                  io_out_d = src[31:28];
                  io_oe_d  = 4'b1111;
                  sr_d     = {src[27:0], 4'h0};
               end else begin
                  io_out_d = {2'b00, src[31], 1'b0};
                  io_oe_d  = 4'b0010;
                  sr_d     = {src[30:0], 1'b0};
               end
               // Prefetch the following word as soon as this one starts.
               if (cnt_q == '0) begin
                  rd_en_d     = 1'b1;
                  dest_sr_d   = 1'b0;
                  word_addr_d = word_addr_q + MEM_AW'(4);
                  mem_addr_d  = word_addr_q + MEM_AW'(4);
               end
               cnt_d       = word_last ? '0 : cnt_q + CW'(1);
               word_done_d = word_last;
            end
         end
         ST_IGNORE: begin
         end
         default: state_d = ST_IDLE;
      endcase

      // Deselect wins over everything, including a coincident sclk edge.
      if (cs_s) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         io_oe_d     = 4'h0;
         rd_en_d     = 1'b0;
         rd_d1_d     = 1'b0;
         word_done_d = 1'b0;
         sr_d        = sr_q;
         nxt_d       = nxt_q;
         cmd_err_d   = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.io_out    = io_out_q;
   assign bus.io_oe     = io_oe_q;
   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign addr_4b_mode  = addr_4b_q;
   assign busy          = busy_q;
   assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: frame-level model of the flash protocol,
// randomized frames, and a per-cycle compare process.
module tb_qspi_flash_responder;

   localparam int unsigned MEM_AW = 32;
   localparam int unsigned DUMMY  = 6;

   logic h_clk = 1'b0;
   logic h_rst;
   logic addr_4b_mode, busy, cmd_err;

   qspi_flash_responder_if #(.MEM_AW(MEM_AW)) bus ();

   qspi_flash_responder #(.DUMMY_CYCLES(DUMMY), .MEM_AW(MEM_AW)) dut (
      .h_clk        (h_clk),
      .h_rst        (h_rst),
      .bus          (bus),
      .addr_4b_mode (addr_4b_mode),
      .busy         (busy),
      .cmd_err      (cmd_err)
   );

   always #5 h_clk = ~h_clk;

   typedef struct {
      bit         chk;
      logic [3:0] oe;
      logic [3:0] val;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   exp_t        exp_q[$];
   logic [3:0]  stim_q[$];
   logic [31:0] fetch_q[$];
   logic [31:0] mem_ovr[logic [31:0]];
   bit          m4b = 1'b0;
   int          exp_err = 0;
   int          err_seen = 0;
   logic        sclk_seen = 1'b0;
   logic [63:0] obs = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
   endfunction

   // Backing memory: data valid the cycle after the strobe, noise otherwise.
   always @(posedge h_clk)
      bus.mem_rdata <= bus.mem_rd_en ? mem_word(bus.mem_addr) : $urandom;

   // Compare process: fetch addresses, cmd_err pulses and pad values at each sclk rise.
   always @(negedge h_clk) begin
      exp_t e;
      if (cmd_err) err_seen++;
      if (bus.mem_rd_en) begin
         if (fetch_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL fetch_extra: mem_addr=%0h, required no fetch at %0t", bus.mem_addr, $time);
         end else begin
            check("fetch_addr", 64'(bus.mem_addr), 64'(fetch_q.pop_front()));
         end
      end
      if (bus.sclk_in && !sclk_seen && !h_rst && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("busy_in_frame", 64'(busy), 64'd1);
         check("io_oe", 64'(bus.io_oe), 64'(e.oe));
         if (e.oe != 4'h0)
            check("io_out", 64'(bus.io_out & e.oe), 64'(e.val & e.oe));
         if (e.oe == 4'b0010)      obs = {obs[62:0], bus.io_out[1]};
         else if (e.oe == 4'b1111) obs = {obs[59:0], bus.io_out};
      end
      sclk_seen = bus.sclk_in;
   end

   function automatic bit is_read(input logic [7:0] op);
      return op == 8'h03 || op == 8'h13 || op == 8'hEB || op == 8'hEC;
   endfunction

   function automatic int hdr_len(input logic [7:0] op);
      bit quad = (op == 8'hEB || op == 8'hEC);
      bit four = (op == 8'h13 || op == 8'hEC || m4b);
      int nb   = four ? 32 : 24;
      return 8 + (quad ? nb / 4 + int'(DUMMY) : nb);
   endfunction

   // Frame model: stimulus per rise, expected pad state per rise, fetch addresses.
   task automatic build(input logic [7:0] op, input logic [31:0] addr, input int total);
      bit quad, four;
      int nb, na, d, nd, n, i;
      logic [31:0] a, base, w;
      exp_err = 0;
      for (int r = 0; r < 8 && r < total; r++) begin
         stim_q.push_back({3'($urandom), op[7-r]});
         exp_q.push_back('{1'b1, 4'h0, 4'h0});
      end
      if (total < 8) return;
      if (!is_read(op)) begin
         if (op == 8'hB7) m4b = 1'b1;
         else             exp_err = 1;
         for (int r = 8; r < total; r++) begin
            stim_q.push_back(4'($urandom));
            exp_q.push_back('{1'b1, 4'h0, 4'h0});
         end
         return;
      end
      quad = (op == 8'hEB || op == 8'hEC);
      four = (op == 8'h13 || op == 8'hEC || m4b);
      a    = four ? addr : {8'h00, addr[23:0]};
      nb   = four ? 32 : 24;
      na   = quad ? nb / 4 : nb;
      for (int k = 0; k < na && 8 + k < total; k++) begin
         if (quad) stim_q.push_back(a[nb-1-4*k -: 4]);
         else      stim_q.push_back({3'($urandom), a[nb-1-k]});
         exp_q.push_back('{1'b1, 4'h0, 4'h0});
      end
      if (total < 8 + na) return;
      base = a & ~32'h3;
      fetch_q.push_back(base);
      d = quad ? int'(DUMMY) : 0;
      for (int k = 0; k < d && 8 + na + k < total; k++) begin
         stim_q.push_back(4'($urandom));
         exp_q.push_back('{1'b1, 4'h0, 4'h0});
      end
      nd = total - 8 - na - d;
      if (nd <= 0) return;
      n = quad ? 8 : 32;
      for (int j = 0; j < nd; j++) begin
         w = mem_word(base + 32'(4 * (j / n)));
         i = j % n;
         stim_q.push_back(4'($urandom));
         if (quad) exp_q.push_back('{1'b1, 4'b1111, w[31-4*i -: 4]});
         else      exp_q.push_back('{1'b1, 4'b0010, {2'b00, w[31-i], 1'b0}});
      end
      for (int k = 1; k <= (nd + n - 1) / n; k++)
         fetch_q.push_back(base + 32'(4 * k));
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge h_clk);
      #1;
   endtask

   // Drive one modelled frame; optionally hit reset before rise rst_after.
   task automatic drive(input int total, input int hc, input int rst_after);
      int e0 = err_seen;
      wait_cyc(1);
      bus.cs_n_in = 1'b0;
      wait_cyc(3 + int'($urandom_range(0, 3)));
      for (int r = 0; r < total; r++) begin
         if (r == rst_after) begin
            h_rst = 1'b1;
            wait_cyc(1);
            check("rst_io_oe", 64'(bus.io_oe), 64'd0);
            check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
            check("rst_addr_4b_mode", 64'(addr_4b_mode), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            wait_cyc(2);
            bus.cs_n_in = 1'b1;
            bus.sclk_in = 1'b0;
            wait_cyc(1);
            h_rst = 1'b0;
            m4b = 1'b0;
            exp_err = 0;
            fetch_q.delete();
            exp_q.delete();
            break;
         end
         bus.io_in = stim_q.pop_front();
         wait_cyc(hc);
         bus.sclk_in = 1'b1;
         wait_cyc(hc);
         if (r == total - 1) bus.cs_n_in = 1'b1;
         bus.sclk_in = 1'b0;
      end
      if (total == 0) wait_cyc(2);
      bus.cs_n_in = 1'b1;
      wait_cyc(8);
      check("fetches_left", 64'(fetch_q.size()), 64'd0);
      check("cmd_err_count", 64'(err_seen - e0), 64'(exp_err));
      check("addr_4b_mode", 64'(addr_4b_mode), 64'(m4b));
      check("busy_after", 64'(busy), 64'd0);
      check("io_oe_after", 64'(bus.io_oe), 64'd0);
      exp_q.delete();
      stim_q.delete();
      fetch_q.delete();
   endtask

   task automatic frame(input logic [7:0] op, input logic [31:0] addr, input int total);
      build(op, addr, total);
      drive(total, int'($urandom_range(4, 6)), -1);
   endtask

   initial begin
      logic [7:0]  op;
      logic [31:0] addr;
      int          total;
      h_rst       = 1'b1;
      bus.sclk_in = 1'b0;
      bus.cs_n_in = 1'b1;
      bus.io_in   = 4'h0;
      wait_cyc(3);
      check("reset_io_oe", 64'(bus.io_oe), 64'd0);
      check("reset_io_out", 64'(bus.io_out), 64'd0);
      check("reset_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
      check("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("reset_addr_4b_mode", 64'(addr_4b_mode), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_cmd_err", 64'(cmd_err), 64'd0);
      h_rst = 1'b0;
      wait_cyc(4);

      // 1-line read of a known word.
      mem_ovr[32'h100] = 32'hDEADBEEF;
      build(8'h03, 32'h0000_0100, 8 + 24 + 32);
      check("pin_fetch_0x100", 64'(fetch_q[0]), 64'h100);
      drive(8 + 24 + 32, 5, -1);
      check("deadbeef_stream", 64'(obs[31:0]), 64'hDEADBEEF);

      // Abort 0x13 after 10 address bits, then a normal read.
      frame(8'h13, 32'hFFFF_FFFC, 18);
      frame(8'h03, 32'h0000_0204, 8 + 24 + 40);

      // Unsupported opcode.
      frame(8'h9F, 32'h0, 24);

      // Quad read of two known words.
      mem_ovr[32'h40] = 32'h01234567;
      mem_ovr[32'h44] = 32'h89ABCDEF;
      build(8'hEB, 32'h0000_0040, 8 + 6 + 6 + 16);
      check("pin_fetch_0x40", 64'(fetch_q[0]), 64'h40);
      check("pin_fetch_0x44", 64'(fetch_q[1]), 64'h44);
      drive(8 + 6 + 6 + 16, 4, -1);
      check("quad_stream", obs, 64'h0123456789ABCDEF);

      // 4-byte mode, then a 4-byte-address read.
      frame(8'hB7, 32'h0, 8);
      build(8'h03, 32'h1234_5678, 8 + 32 + 8);
      check("pin_fetch_4b", 64'(fetch_q[0]), 64'h1234_5678);
      drive(8 + 32 + 8, 5, -1);

      // Reset mid-DATA.
      build(8'h03, 32'h0000_0300, 80);
      drive(80, 5, 50);

      // Randomized frames.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 7))
            0, 6:    op = 8'h03;
            1:       op = 8'h13;
            2, 7:    op = 8'hEB;
            3:       op = 8'hEC;
            4:       op = ($urandom_range(0, 2) == 0) ? 8'hB7 : 8'h03;
            default: begin
               op = 8'($urandom);
               while (is_read(op) || op == 8'hB7) op = 8'($urandom);
            end
         endcase
         addr = $urandom;
         if (!is_read(op))                    total = int'($urandom_range(0, 20));
         else if ($urandom_range(0, 3) == 0)  total = int'($urandom_range(0, hdr_len(op)));
         else                                 total = hdr_len(op) + int'($urandom_range(1, 40));
         frame(op, addr, total);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
